// File: rtl/lsu_bus_master_if.sv
// Core-side request/response and memory-side req/gnt/rvalid signals of the LSU bus master.
// The master modport is the LSU's view; the slave modport is the core/memory environment's view.
interface lsu_bus_master_if #(
   parameter int XLEN = 32
);
   logic            core_req_valid_i;
   logic            core_req_ready_o;
   logic            core_we_i;
   logic [2:0]      core_funct3_i;
   logic [XLEN-1:0] core_addr_i;
   logic [XLEN-1:0] core_wdata_i;
   logic            core_rsp_valid_o;
   logic [XLEN-1:0] core_rsp_rdata_o;
   logic            core_rsp_err_o;
   logic            core_rsp_misalign_o;
   logic            mem_req_o;
   logic            mem_gnt_i;
   logic            mem_we_o;
   logic [3:0]      mem_be_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;
   logic            mem_err_i;

   modport master (
      input  core_req_valid_i, core_we_i, core_funct3_i, core_addr_i, core_wdata_i,
      output core_req_ready_o, core_rsp_valid_o, core_rsp_rdata_o, core_rsp_err_o,
             core_rsp_misalign_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );

   modport slave (
      output core_req_valid_i, core_we_i, core_funct3_i, core_addr_i, core_wdata_i,
      input  core_req_ready_o, core_rsp_valid_o, core_rsp_rdata_o, core_rsp_err_o,
             core_rsp_misalign_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one outstanding word-aligned bus transaction, response 3 cycles after accept
// with immediate gnt/rvalid (1 cycle for rejected requests); no response back-pressure, timeout guard.
module lsu_bus_master #(
   parameter int  XLEN    = 32,
   parameter int  TIMEOUT = 16,
   localparam int TMO_W   = $clog2(TIMEOUT + 1)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   lsu_bus_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic [3:0]        be_q;
   logic              err_q;
   logic              mis_q;
   logic [TMO_W-1:0]  cnt;
   logic [TMO_W-1:0]  cnt_inc;
   logic              tmo;

   logic [1:0]        size_in;
   logic [1:0]        off_in;
   logic              illegal;
   logic              misal;
   logic [3:0]        be_in;
   logic [XLEN-1:0]   wdata_in;
   logic [7:0]        byte_l;
   logic [15:0]       half_l;
   logic [XLEN-1:0]   load_ext;

   // Request decode, evaluated on the incoming core request while IDLE.
   assign size_in = bus.core_funct3_i[1:0];
   assign off_in  = bus.core_addr_i[1:0];
   assign illegal = (size_in == 2'b11) || (bus.core_funct3_i == 3'b110) ||
                    (bus.core_we_i && bus.core_funct3_i[2]);
   assign misal   = ((size_in == 2'b01) && off_in[0]) ||
                    ((size_in == 2'b10) && (off_in != 2'b00));

   always_comb begin
      be_in    = 4'b1111;
      wdata_in = bus.core_wdata_i;
      case (size_in)
         2'b00: begin
            be_in    = 4'b0001 << off_in;
            wdata_in = {4{bus.core_wdata_i[7:0]}};
         end
         2'b01: begin
            be_in    = 4'b0011 << off_in;
            wdata_in = {2{bus.core_wdata_i[15:0]}};
         end
         default: begin
            be_in    = 4'b1111;
            wdata_in = bus.core_wdata_i;
         end
      endcase
   end

   // Lane steering and extension of the returned word.
   assign byte_l = 8'(bus.mem_rdata_i >> {off_q, 3'b000});
   assign half_l = off_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];

   always_comb begin
      load_ext = bus.mem_rdata_i;
      case (f3_q)
         3'b000:  load_ext = {{(XLEN-8){byte_l[7]}}, byte_l};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_l};
         3'b001:  load_ext = {{(XLEN-16){half_l[15]}}, half_l};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_l};
         default: load_ext = bus.mem_rdata_i;
      endcase
   end

   assign cnt_inc = cnt + 1'b1;
   assign tmo     = (cnt_inc == TMO_W'(TIMEOUT));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt                = state;
      bus.core_req_ready_o     = 1'b0;
      bus.core_rsp_valid_o     = 1'b0;
      bus.core_rsp_rdata_o     = '0;
      bus.core_rsp_err_o       = 1'b0;
      bus.core_rsp_misalign_o  = 1'b0;
      bus.mem_req_o            = 1'b0;
      bus.mem_we_o             = 1'b0;
      bus.mem_be_o             = 4'b0000;
      bus.mem_addr_o           = '0;
      bus.mem_wdata_o          = '0;
      case (state)
         IDLE: begin
            bus.core_req_ready_o = 1'b1;
            if (bus.core_req_valid_i) begin
               state_nxt = (illegal || misal) ? RESP : REQ;
            end
         end
         REQ: begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = we_q;
            bus.mem_be_o    = be_q;
            bus.mem_addr_o  = addr_q;
            bus.mem_wdata_o = wdata_q;
            if (tmo) begin
               state_nxt = RESP;
            end else if (bus.mem_gnt_i) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // A response landing in the timeout cycle is still honoured.
            if (bus.mem_rvalid_i || tmo) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            bus.core_rsp_valid_o    = 1'b1;
            bus.core_rsp_rdata_o    = rdata_q;
            bus.core_rsp_err_o      = err_q;
            bus.core_rsp_misalign_o = mis_q;
            state_nxt               = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= 4'b0000;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.core_req_valid_i) begin
                  we_q    <= bus.core_we_i;
                  f3_q    <= bus.core_funct3_i;
                  off_q   <= off_in;
                  addr_q  <= {bus.core_addr_i[XLEN-1:2], 2'b00};
                  be_q    <= be_in;
                  wdata_q <= wdata_in;
                  rdata_q <= '0;
                  err_q   <= illegal || misal;
                  mis_q   <= !illegal && misal;
               end
            end
            REQ: begin
               cnt <= cnt_inc;
               if (tmo) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt_inc;
               if (bus.mem_rvalid_i) begin
                  err_q   <= bus.mem_err_i;
                  rdata_q <= (we_q || bus.mem_err_i) ? '0 : load_ext;
               end else if (tmo) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator that drives an external data-memory bus with a request/grant/response handshake.
- Sits between the execute stage and the data memory; the memory stage becomes a pure responder.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned bus transactions with byte enables, lane steering and sign/zero extension.
- One transaction outstanding at a time; a timeout guard prevents a hung bus from stalling the core.

Parameters:
- XLEN, 32, data/address width; only 32 is supported (4 byte lanes).
- TIMEOUT, 16, max cycles from entering REQ to mem_rvalid_i before an error response; must be >= 2.
- TMO_W, $clog2(TIMEOUT+1), timeout counter width (derived; not to be overridden).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- core_req_valid_i  in  1  core request valid.
- core_req_ready_o  out  1  block can accept a request (high only in IDLE).
- core_we_i  in  1  1 = store, 0 = load.
- core_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_addr_i  in  XLEN  byte address.
- core_wdata_i  in  XLEN  store data (LSBs significant).
- core_rsp_valid_o  out  1  one-cycle response pulse.
- core_rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- core_rsp_err_o  out  1  bus error, timeout, misalignment or illegal funct3.
- core_rsp_misalign_o  out  1  error cause is misalignment.
- mem_req_o  out  1  bus request.
- mem_gnt_i  in  1  bus accepted the request this cycle.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  XLEN  word address: {addr[XLEN-1:2], 2'b00}.
- mem_wdata_o  out  XLEN  lane-replicated write data.
- mem_rvalid_i  in  1  response valid; also the acknowledge for stores.
- mem_rdata_i  in  XLEN  read word.
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0.
  - All outputs 0 except core_req_ready_o = 1.
  - Asserting rst_i mid-transaction drops mem_req_o immediately and emits no response.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - core_req_ready_o = 1.
  - On core_req_valid_i, register we, funct3, addr[1:0], word address, be and wdata.
  - If funct3 is illegal (011/110/111, or store with funct3[2] = 1), go to RESP with err = 1, misalign = 0.
  - If misaligned (H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 0), go to RESP with err = 1, misalign = 1.
  - Otherwise go to REQ. No bus activity occurs for rejected requests.
- REQ:
  - mem_req_o = 1; bus outputs held stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT.
  - mem_rvalid_i in the grant cycle is ignored; the response comes no earlier than the cycle after grant.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i, capture data and err, go to RESP.
- RESP:
  - core_rsp_valid_o = 1 for exactly one cycle, then IDLE. No back-pressure.
- Timeout:
  - Counter clears on leaving IDLE and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no mem_rvalid_i, go to RESP with err = 1, misalign = 0.
  - If mem_rvalid_i arrives in that same cycle, mem_rvalid_i wins (a normal response).
  - mem_rvalid_i seen in IDLE, REQ or RESP is ignored.
- Byte enables, with off = addr[1:0]:
  - B/BU/SB: be = 4'b0001 << off.
  - H/HU/SH: be = 4'b0011 << off.
  - W/SW: be = 4'b1111.
- Write data: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes through.
- Load extraction: byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- rdata is forced to 0 for stores and for any error.
- Latency (grant and response immediate): request accepted at cycle 0, mem_req_o at cycle 1, mem_rvalid_i at cycle 2, core_rsp_valid_o at cycle 3.
  - Rejected requests: core_rsp_valid_o at cycle 1.
- Back-to-back: the next request can be accepted in the cycle after RESP.

Test Plan:
- LB addr 0x103, rdata 0x80FF_1234, immediate gnt/rvalid -> mem_addr_o 0x100, be 4'b1000, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid at cycle 3.
- LHU addr 0x202, rdata 0x9ABC_5678 -> be 4'b1100, rdata 0x0000_9ABC. LH same -> 0xFFFF_9ABC.
- SH addr 0x002, wdata 0x1234_ABCD -> mem_wdata 0xABCD_ABCD, be 4'b1100, we 1; gnt delayed 3 cycles -> mem_req_o held 4 cycles with stable outputs; rsp rdata 0.
- LW addr 0x006 -> no mem_req_o, rsp_valid at cycle 1, err 1, misalign 1. Store with funct3 100 -> err 1, misalign 0.
- TIMEOUT=16, gnt immediate, rvalid never -> rsp err 1 exactly 16 cycles after entering REQ; then IDLE, ready 1. rvalid with mem_err_i 1 -> err 1, rdata 0.
- Assert rst_i during WAIT -> mem_req_o, core_rsp_valid_o 0 asynchronously, ready 1; release, issue SW addr 0x40 -> normal completion.
